// File: rtl/kappa3_mem_responder.sv
// Memory-side responder for the Kappa3 datapath: serves byte-lane masked
// reads/writes from an internal word RAM after a fixed number of wait cycles.
module kappa3_mem_responder #(
  parameter int ADDR_WIDTH  = 12,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] mem_addr,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [3:0]  mem_wrbits,
  input  logic [31:0] mem_wrdata,
  output logic [31:0] mem_rddata,
  output logic        mem_ready,
  output logic        mem_err,
  output logic        mem_busy
);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} state_t;

  localparam int         DEPTH    = 1 << ADDR_WIDTH;
  localparam logic [3:0] CNT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  state_t      state, next_state;
  logic [3:0]  cnt, cnt_next;
  logic [31:0] req_addr, req_wrdata;
  logic [3:0]  req_wrbits;
  logic        req_rd, req_wr;

  logic [31:0] ram [DEPTH];

  logic                  accept, commit, c_err, lanes_ok;
  logic [31:0]           c_addr, c_wrdata;
  logic [3:0]            c_wrbits;
  logic                  c_rd, c_wr;
  logic [ADDR_WIDTH-1:0] c_idx;

  // With zero wait cycles the commit happens on the sampling edge itself,
  // so the request being committed comes straight from the ports.
  always_comb begin
    accept = (state == ST_IDLE) && (mem_read || mem_write);
    if (state == ST_IDLE) begin
      c_addr   = mem_addr;
      c_wrdata = mem_wrdata;
      c_wrbits = mem_wrbits;
      c_rd     = mem_read;
      c_wr     = mem_write;
    end else begin
      c_addr   = req_addr;
      c_wrdata = req_wrdata;
      c_wrbits = req_wrbits;
      c_rd     = req_rd;
      c_wr     = req_wr;
    end
    c_idx  = c_addr[ADDR_WIDTH+1:2];
    commit = reset && ((accept && (WAIT_CYCLES == 0)) ||
                       ((state == ST_WAIT) && (cnt == 4'd0)));

    case (c_wrbits)
      4'b0001: lanes_ok = (c_addr[1:0] == 2'd0);
      4'b0010: lanes_ok = (c_addr[1:0] == 2'd1);
      4'b0100: lanes_ok = (c_addr[1:0] == 2'd2);
      4'b1000: lanes_ok = (c_addr[1:0] == 2'd3);
      4'b0011: lanes_ok = (c_addr[1:0] == 2'd0);
      4'b1100: lanes_ok = (c_addr[1:0] == 2'd2);
      4'b1111: lanes_ok = (c_addr[1:0] == 2'd0);
      default: lanes_ok = 1'b0;
    endcase

    c_err = (c_rd && c_wr) ||
            ((c_addr >> (ADDR_WIDTH + 2)) != 32'd0) ||
            (c_wr && !lanes_ok);
  end

  always_comb begin
    next_state = state;
    cnt_next   = cnt;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (WAIT_CYCLES == 0) begin
            next_state = ST_DONE;
          end else begin
            next_state = ST_WAIT;
            cnt_next   = CNT_LOAD;
          end
        end
      end
      ST_WAIT: begin
        if (cnt == 4'd0) next_state = ST_DONE;
        else             cnt_next   = cnt - 4'd1;
      end
      ST_DONE: next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      cnt        <= 4'd0;
      req_addr   <= 32'd0;
      req_wrdata <= 32'd0;
      req_wrbits <= 4'd0;
      req_rd     <= 1'b0;
      req_wr     <= 1'b0;
      mem_rddata <= 32'd0;
      mem_ready  <= 1'b0;
      mem_err    <= 1'b0;
      mem_busy   <= 1'b0;
    end else begin
      state     <= next_state;
      cnt       <= cnt_next;
      mem_busy  <= (next_state != ST_IDLE);
      mem_ready <= (next_state == ST_DONE);
      mem_err   <= commit && c_err;
      if (accept) begin
        req_addr   <= mem_addr;
        req_wrdata <= mem_wrdata;
        req_wrbits <= mem_wrbits;
        req_rd     <= mem_read;
        req_wr     <= mem_write;
      end
      if (commit && c_err)      mem_rddata <= 32'd0;
      else if (commit && c_rd)  mem_rddata <= ram[c_idx];
    end
  end

  // RAM content is deliberately not reset; only committed legal writes touch it.
  always_ff @(posedge clock) begin
    if (commit && c_wr && !c_err) begin
      for (int i = 0; i < 4; i++) begin
        if (c_wrbits[i]) ram[c_idx][8*i +: 8] <= c_wrdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_kappa3_mem_responder.sv
// Directed self-checking bench for kappa3_mem_responder: one instance with
// two wait cycles and one with zero wait cycles.
module tb_kappa3_mem_responder;

  logic clock = 1'b0;
  logic reset;

  logic [31:0] a_addr, a_wrdata, a_rddata;
  logic        a_read, a_write, a_ready, a_err, a_busy;
  logic [3:0]  a_wrbits;

  logic [31:0] b_addr, b_wrdata, b_rddata;
  logic        b_read, b_write, b_ready, b_err, b_busy;
  logic [3:0]  b_wrbits;

  int total = 0;
  int bad   = 0;

  int   lat, busy_cnt, ready_cnt;
  logic err;

  always #5 clock = ~clock;

  kappa3_mem_responder #(.ADDR_WIDTH(12), .WAIT_CYCLES(2)) dut_a (
    .clock(clock), .reset(reset),
    .mem_addr(a_addr), .mem_read(a_read), .mem_write(a_write),
    .mem_wrbits(a_wrbits), .mem_wrdata(a_wrdata), .mem_rddata(a_rddata),
    .mem_ready(a_ready), .mem_err(a_err), .mem_busy(a_busy)
  );

  kappa3_mem_responder #(.ADDR_WIDTH(4), .WAIT_CYCLES(0)) dut_b (
    .clock(clock), .reset(reset),
    .mem_addr(b_addr), .mem_read(b_read), .mem_write(b_write),
    .mem_wrbits(b_wrbits), .mem_wrdata(b_wrdata), .mem_rddata(b_rddata),
    .mem_ready(b_ready), .mem_err(b_err), .mem_busy(b_busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit sel, input logic rd, input logic wr,
                       input logic [31:0] addr, input logic [3:0] bits,
                       input logic [31:0] data);
    if (sel) begin
      b_read = rd; b_write = wr; b_addr = addr; b_wrbits = bits; b_wrdata = data;
    end else begin
      a_read = rd; a_write = wr; a_addr = addr; a_wrbits = bits; a_wrdata = data;
    end
  endtask

  // Issues one request (sampled at the end of cycle N), then watches cycles
  // N+1..N+12, recording the first ready cycle, busy cycles and ready pulses.
  // A second read of 0x20 can be injected at relative cycle extra_at.
  task automatic access(input bit sel, input logic rd, input logic wr,
                        input logic [31:0] addr, input logic [3:0] bits,
                        input logic [31:0] data, input int extra_at,
                        output int o_lat, output int o_busy, output int o_ready,
                        output logic o_err);
    logic rdy, bsy, er;
    o_lat = -1; o_busy = 0; o_ready = 0; o_err = 1'bx;
    @(negedge clock);
    drive(sel, rd, wr, addr, bits, data);
    @(negedge clock);
    for (int i = 1; i <= 12; i++) begin
      rdy = sel ? b_ready : a_ready;
      bsy = sel ? b_busy  : a_busy;
      er  = sel ? b_err   : a_err;
      if (bsy) o_busy++;
      if (rdy) begin
        o_ready++;
        if (o_lat < 0) begin
          o_lat = i;
          o_err = er;
        end
      end
      if (i == extra_at) drive(sel, 1'b1, 1'b0, 32'h20, 4'h0, 32'h0);
      else               drive(sel, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
      @(negedge clock);
    end
  endtask

  initial begin
    reset = 1'b0;
    drive(0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);

    @(negedge clock);
    check("rst_rddata", a_rddata, 32'h0);
    check("rst_ready", {31'd0, a_ready}, 32'd0);
    check("rst_err", {31'd0, a_err}, 32'd0);
    check("rst_busy", {31'd0, a_busy}, 32'd0);
    reset = 1'b1;

    $display("[TB] word write/read");
    access(0, 1'b0, 1'b1, 32'h10, 4'b1111, 32'hDEADBEEF, 0, lat, busy_cnt, ready_cnt, err);
    check("sw_lat", 32'(lat), 32'd3);
    check("sw_err", {31'd0, err}, 32'd0);
    check("sw_pulses", 32'(ready_cnt), 32'd1);
    check("sw_busy", 32'(busy_cnt), 32'd3);
    access(0, 1'b1, 1'b0, 32'h10, 4'h0, 32'h0, 0, lat, busy_cnt, ready_cnt, err);
    check("lw_lat", 32'(lat), 32'd3);
    check("lw_err", {31'd0, err}, 32'd0);
    check("lw_busy", 32'(busy_cnt), 32'd3);
    check("lw_data", a_rddata, 32'hDEADBEEF);

    $display("[TB] byte/half lanes");
    // Byte 0xAA stored at 0x11 travels in lane 1.
    access(0, 1'b0, 1'b1, 32'h11, 4'b0010, 32'h0000AA00, 0, lat, busy_cnt, ready_cnt, err);
    check("sb_err", {31'd0, err}, 32'd0);
    check("sb_rddata_held", a_rddata, 32'hDEADBEEF);
    access(0, 1'b0, 1'b1, 32'h12, 4'b1100, 32'h12340000, 0, lat, busy_cnt, ready_cnt, err);
    check("sh_err", {31'd0, err}, 32'd0);
    access(0, 1'b1, 1'b0, 32'h10, 4'h0, 32'h0, 0, lat, busy_cnt, ready_cnt, err);
    check("lanes_data", a_rddata, 32'h1234AAEF);

    $display("[TB] error requests");
    access(0, 1'b1, 1'b0, 32'h00004000, 4'h0, 32'h0, 0, lat, busy_cnt, ready_cnt, err);
    check("oor_lat", 32'(lat), 32'd3);
    check("oor_err", {31'd0, err}, 32'd1);
    check("oor_data", a_rddata, 32'h0);
    access(0, 1'b1, 1'b0, 32'h10, 4'h0, 32'h0, 0, lat, busy_cnt, ready_cnt, err);
    check("reload_data", a_rddata, 32'h1234AAEF);
    access(0, 1'b0, 1'b1, 32'h12, 4'b0011, 32'hFFFFFFFF, 0, lat, busy_cnt, ready_cnt, err);
    check("badlane_err", {31'd0, err}, 32'd1);
    check("badlane_data", a_rddata, 32'h0);
    access(0, 1'b1, 1'b1, 32'h10, 4'b1111, 32'h0, 0, lat, busy_cnt, ready_cnt, err);
    check("rdwr_err", {31'd0, err}, 32'd1);
    check("rdwr_pulses", 32'(ready_cnt), 32'd1);
    access(0, 1'b0, 1'b1, 32'h13, 4'b0001, 32'h000000FF, 0, lat, busy_cnt, ready_cnt, err);
    check("b0_at3_err", {31'd0, err}, 32'd1);
    access(0, 1'b0, 1'b1, 32'h10, 4'b0000, 32'hFFFFFFFF, 0, lat, busy_cnt, ready_cnt, err);
    check("nobits_err", {31'd0, err}, 32'd1);
    access(0, 1'b1, 1'b0, 32'h10, 4'h0, 32'h0, 0, lat, busy_cnt, ready_cnt, err);
    check("err_ram_kept", a_rddata, 32'h1234AAEF);
    access(0, 1'b0, 1'b1, 32'h13, 4'b1000, 32'h77000000, 0, lat, busy_cnt, ready_cnt, err);
    check("b3_err", {31'd0, err}, 32'd0);

    $display("[TB] ignored request");
    access(0, 1'b0, 1'b1, 32'h20, 4'b1111, 32'h11111111, 0, lat, busy_cnt, ready_cnt, err);
    access(0, 1'b1, 1'b0, 32'h10, 4'h0, 32'h0, 1, lat, busy_cnt, ready_cnt, err);
    check("ign_pulses", 32'(ready_cnt), 32'd1);
    check("ign_lat", 32'(lat), 32'd3);
    check("ign_data", a_rddata, 32'h7734AAEF);

    $display("[TB] reset mid-write");
    @(negedge clock);
    drive(0, 1'b0, 1'b1, 32'h20, 4'b1111, 32'h55555555);
    @(negedge clock);
    drive(0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    check("mid_busy", {31'd0, a_busy}, 32'd1);
    #1 reset = 1'b0;
    #1;
    check("mid_rst_busy", {31'd0, a_busy}, 32'd0);
    check("mid_rst_ready", {31'd0, a_ready}, 32'd0);
    check("mid_rst_err", {31'd0, a_err}, 32'd0);
    check("mid_rst_data", a_rddata, 32'h0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    access(0, 1'b1, 1'b0, 32'h20, 4'h0, 32'h0, 0, lat, busy_cnt, ready_cnt, err);
    check("post_rst_lat", 32'(lat), 32'd3);
    check("post_rst_data", a_rddata, 32'h11111111);

    $display("[TB] zero wait cycles");
    access(1, 1'b0, 1'b1, 32'h8, 4'b1111, 32'hCAFEF00D, 0, lat, busy_cnt, ready_cnt, err);
    check("w0_sw_lat", 32'(lat), 32'd1);
    check("w0_sw_busy", 32'(busy_cnt), 32'd1);
    check("w0_sw_err", {31'd0, err}, 32'd0);
    access(1, 1'b1, 1'b0, 32'h8, 4'h0, 32'h0, 0, lat, busy_cnt, ready_cnt, err);
    check("w0_lw_lat", 32'(lat), 32'd1);
    check("w0_lw_busy", 32'(busy_cnt), 32'd1);
    check("w0_lw_data", b_rddata, 32'hCAFEF00D);
    access(1, 1'b1, 1'b0, 32'h40, 4'h0, 32'h0, 0, lat, busy_cnt, ready_cnt, err);
    check("w0_oor_err", {31'd0, err}, 32'd1);
    check("w0_oor_data", b_rddata, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
